// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_pkg
// Description : Shared types and constants for the sequential ALU: operation
//               encoding, FSM state encoding and CMP result bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

    // Operation codes; the numeric order is fixed by the instruction decoder.
    typedef enum logic [3:0] {
        ADD    = 4'd0,
        SUB    = 4'd1,
        MUL    = 4'd2,
        DIV    = 4'd3,
        MOD    = 4'd4,
        SHL    = 4'd5,
        SHR    = 4'd6,
        AND    = 4'd7,
        OR     = 4'd8,
        XOR    = 4'd9,
        NOR    = 4'd10,
        POPCNT = 4'd11,
        CLZ    = 4'd12,
        CTZ    = 4'd13,
        XXX    = 4'd14,
        CMP    = 4'd15
    } alu_op_t;

    // FSM states. Prefixed so they do not collide with the DIV opcode.
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } alu_state_t;

    // Bit positions inside the CMP result word {0..., gt, eq, lt}.
    localparam int CMP_LT_BIT = 0;
    localparam int CMP_EQ_BIT = 1;
    localparam int CMP_GT_BIT = 2;

    function automatic logic is_divmod(input alu_op_t op);
        return (op == DIV) || (op == MOD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_if
// Description : Operand/result handshake bundle of the sequential ALU.
//               master : issues operations, consumes results
//               slave  : the ALU itself
//   in_valid/in_ready   operand-side handshake
//   op, op_signed       operation and signedness
//   ra, rb              operands (WIDTH bits)
//   out_valid/out_ready result-side handshake
//   result, flag_*      registered result and status flags
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    import seq_alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    alu_op_t          op;
    logic             op_signed;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_dz;

    modport master (
        output in_valid, op, op_signed, ra, rb, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_carry, flag_dz
    );

    modport slave (
        input  in_valid, op, op_signed, ra, rb, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_carry, flag_dz
    );

endinterface
`default_nettype wire

// File: rtl/seq_alu_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Unsigned restoring divider, one quotient bit per cycle.
//   clk, reset          clock, synchronous active-high reset
//   start               load dividend/divisor and begin WIDTH iterations
//   dividend, divisor   unsigned operands (divisor must be non-zero)
//   quotient, remainder results of the step taken this cycle; final when done
//   busy                iterations in progress
//   done                the final iteration is being taken this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic [WIDTH-1:0] dividend,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH-1:0] quotient,
    output logic      [WIDTH-1:0] remainder,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;      // dividend bits shift out the top, quotient bits in at the bottom
    logic [WIDTH-1:0] dvsr_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;

    // Partial remainder stays below 2*divisor, so WIDTH+1 bits hold the trial.
    assign w_shift   = {rem_q, quo_q[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, dvsr_q};
    assign w_ge      = ~w_trial[WIDTH];

    // Outputs are the step's next values so the caller can register the final
    // answer on the same edge as the last iteration.
    assign quotient  = {quo_q[WIDTH-2:0], w_ge};
    assign remainder = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvsr_q <= divisor;
            cnt_q  <= CW'(WIDTH);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= remainder;
            quo_q  <= quotient;
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Multi-cycle ALU with valid/ready handshakes. Single-cycle
//               arithmetic/logic ops, WIDTH-cycle iterative DIV/MOD (signed
//               or unsigned) and registered zero/carry/divide-by-zero flags.
//   clk    clock
//   reset  synchronous active-high reset
//   bus    seq_alu_if.slave: operand handshake, op, ra/rb, result handshake,
//          result and flags
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic clk,
    input  wire logic reset,
    seq_alu_if.slave  bus
);
    import seq_alu_pkg::*;

    alu_state_t       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             dz_q, dz_d;
    logic             is_mod_q, is_mod_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;

    logic             w_accept;
    logic             w_ra_neg, w_rb_neg;
    logic [WIDTH-1:0] w_ra_mag, w_rb_mag;
    logic [WIDTH:0]   w_sum, w_diff;
    logic             w_lt, w_eq, w_gt;
    logic             w_shift_big;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_pop, w_clz, w_ctz;
    logic [WIDTH-1:0] w_alu_res, w_imm_res;
    logic             w_alu_carry;
    logic             w_div_start, w_div_busy, w_div_done;
    logic [WIDTH-1:0] w_div_quo, w_div_rem, w_div_sel, w_div_fix;

    assign bus.in_ready   = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready) && !reset;
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_dz    = dz_q;

    assign w_accept = bus.in_valid && bus.in_ready;

    // Signed division runs on magnitudes; MIN maps onto itself, which read as
    // unsigned is exactly its magnitude.
    assign w_ra_neg = bus.op_signed && bus.ra[WIDTH-1];
    assign w_rb_neg = bus.op_signed && bus.rb[WIDTH-1];
    assign w_ra_mag = w_ra_neg ? -bus.ra : bus.ra;
    assign w_rb_mag = w_rb_neg ? -bus.rb : bus.rb;

    assign w_sum       = {1'b0, bus.ra} + {1'b0, bus.rb};
    assign w_diff      = {1'b0, bus.ra} - {1'b0, bus.rb};
    assign w_eq        = (bus.ra == bus.rb);
    assign w_lt        = bus.op_signed ? ($signed(bus.ra) < $signed(bus.rb)) : (bus.ra < bus.rb);
    assign w_gt        = !w_lt && !w_eq;
    assign w_shift_big = (bus.rb >= WIDTH'(WIDTH));
    assign w_shamt     = bus.rb[SHW-1:0];

    // Bit counters. CLZ keeps the highest set bit seen, CTZ the lowest.
    always_comb begin
        w_pop = '0;
        w_clz = WIDTH'(WIDTH);
        w_ctz = WIDTH'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.ra[i]) begin
                w_pop = w_pop + WIDTH'(1);
                w_clz = WIDTH'(WIDTH - 1 - i);
            end
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bus.ra[i]) begin
                w_ctz = WIDTH'(i);
            end
        end
    end

    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (bus.op)
            ADD: begin
                w_alu_res   = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
            end
            SUB: begin
                w_alu_res   = w_diff[WIDTH-1:0];
                w_alu_carry = w_diff[WIDTH];
            end
            MUL:    w_alu_res = bus.ra * bus.rb;
            SHL:    w_alu_res = w_shift_big ? '0 : (bus.ra << w_shamt);
            SHR: begin
                if (bus.op_signed) begin
                    w_alu_res = w_shift_big ? {WIDTH{bus.ra[WIDTH-1]}}
                                            : ($signed(bus.ra) >>> w_shamt);
                end else begin
                    w_alu_res = w_shift_big ? '0 : (bus.ra >> w_shamt);
                end
            end
            AND:    w_alu_res = bus.ra & bus.rb;
            OR:     w_alu_res = bus.ra | bus.rb;
            XOR:    w_alu_res = bus.ra ^ bus.rb;
            NOR:    w_alu_res = ~(bus.ra | bus.rb);
            POPCNT: w_alu_res = w_pop;
            CLZ:    w_alu_res = w_clz;
            CTZ:    w_alu_res = w_ctz;
            XXX:    w_alu_res = result_q;
            CMP: begin
                w_alu_res[CMP_LT_BIT] = w_lt;
                w_alu_res[CMP_EQ_BIT] = w_eq;
                w_alu_res[CMP_GT_BIT] = w_gt;
                w_alu_carry           = w_diff[WIDTH];
            end
            default: w_alu_res = '0;
        endcase
    end

    // Immediate result: only reached for DIV/MOD when rb is zero.
    assign w_imm_res = !is_divmod(bus.op) ? w_alu_res
                     : (bus.op == DIV)    ? {WIDTH{1'b1}}
                     :                      bus.ra;

    // Quotient is negative when operand signs differ; remainder follows the dividend.
    assign w_div_sel = is_mod_q ? w_div_rem : w_div_quo;
    assign w_div_fix = (is_mod_q ? r_neg_q : q_neg_q) ? -w_div_sel : w_div_sel;

    seq_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (w_div_start),
        .dividend  (w_ra_mag),
        .divisor   (w_rb_mag),
        .quotient  (w_div_quo),
        .remainder (w_div_rem),
        .busy      (w_div_busy),
        .done      (w_div_done)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        result_d    = result_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        dz_d        = dz_q;
        is_mod_d    = is_mod_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        w_div_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (is_divmod(bus.op) && (bus.rb != '0)) begin
                        state_d     = S_DIV;
                        w_div_start = 1'b1;
                        is_mod_d    = (bus.op == MOD);
                        q_neg_d     = w_ra_neg ^ w_rb_neg;
                        r_neg_d     = w_ra_neg;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = w_imm_res;
                        zero_d      = (w_imm_res == '0);
                        carry_d     = w_alu_carry;
                        dz_d        = is_divmod(bus.op);
                    end
                end
            end
            S_DIV: begin
                // A pending result cannot exist here: accept only happens once
                // the previous result is gone, so completion never has to stall.
                if (w_div_done) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = w_div_fix;
                    zero_d      = (w_div_fix == '0);
                    carry_d     = 1'b0;
                    dz_d        = 1'b0;
                end else if (!w_div_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            dz_q        <= 1'b0;
            is_mod_q    <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            dz_q        <= dz_d;
            is_mod_q    <= is_mod_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu (WIDTH=16 main instance and
//               a WIDTH=8 instance for narrow-width corner cases).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic [15:0] model_prev;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();
    seq_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    seq_alu_if #(.WIDTH(8)) bus8 ();
    seq_alu #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    // Reference model from the arithmetic definitions, WIDTH=16.
    function automatic void model(input alu_op_t o, input bit s, input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] prev, output logic [15:0] r, output bit z,
                                  output bit c, output bit dz);
        int     sa, sb, t;
        longint p;
        bit     lt, eq, gt;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r = 16'h0; c = 1'b0; dz = 1'b0;
        case (o)
            ADD: begin t = int'(a) + int'(b); r = t[15:0]; c = (t > 65535); end
            SUB: begin t = int'(a) - int'(b); r = t[15:0]; c = (a < b); end
            MUL: begin p = longint'(a) * longint'(b); r = p[15:0]; end
            DIV: begin
                if (b == 0) begin r = 16'hFFFF; dz = 1'b1; end
                else if (s) begin t = sa / sb; r = t[15:0]; end
                else r = a / b;
            end
            MOD: begin
                if (b == 0) begin r = a; dz = 1'b1; end
                else if (s) begin t = sa % sb; r = t[15:0]; end
                else r = a % b;
            end
            SHL: begin t = int'(a) << b; r = (b >= 16) ? 16'h0 : t[15:0]; end
            SHR: begin
                if (b >= 16) r = (s && a[15]) ? 16'hFFFF : 16'h0;
                else if (s) begin t = sa >>> b; r = t[15:0]; end
                else r = a >> b;
            end
            AND: r = a & b;
            OR:  r = a | b;
            XOR: r = a ^ b;
            NOR: r = ~(a | b);
            POPCNT: begin t = $countones(a); r = t[15:0]; end
            CLZ: begin t = 0; while (t < 16 && !a[15-t]) t++; r = t[15:0]; end
            CTZ: begin t = 0; while (t < 16 && !a[t]) t++; r = t[15:0]; end
            XXX: r = prev;
            CMP: begin
                lt = s ? (sa < sb) : (a < b);
                eq = (a == b);
                gt = s ? (sa > sb) : (a > b);
                r  = {13'h0, gt, eq, lt};
                c  = (a < b);
            end
            default: r = 16'h0;
        endcase
        z = (r == 16'h0);
    endfunction

    task automatic drive(input alu_op_t o, input bit s, input logic [15:0] a, input logic [15:0] b);
        bus.op = o; bus.op_signed = s; bus.ra = a; bus.rb = b; bus.in_valid = 1'b1;
    endtask

    // Holds the request until accepted (bounded), returns in cycle N+1.
    task automatic issue(input alu_op_t o, input bit s, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        drive(o, s, a, b);
        while (!bus.in_ready && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Cycles from accept until out_valid is seen; -1 on timeout.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!bus.out_valid && lat <= 100) begin @(posedge clk); #1; lat++; end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++;
        if ({bus.out_valid, bus.result, bus.flag_zero, bus.flag_carry, bus.flag_dz} !== 20'h0) begin
            failures++; $display("FAIL reset_outputs: got ov=%b r=%h z=%b c=%b dz=%b expected all 0",
                                 bus.out_valid, bus.result, bus.flag_zero, bus.flag_carry, bus.flag_dz);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1;
        model_prev = 16'h0;
    endtask

    task automatic test_add;
        int lat;
        issue(ADD, 1'b0, 16'hFFFF, 16'h0001);
        wait_result(lat);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL add_latency: got %0d expected 1", lat); end
        checks++;
        if ({bus.result, bus.flag_zero, bus.flag_carry, bus.flag_dz} !== {16'h0000, 3'b110}) begin
            failures++; $display("FAIL add_wrap: got r=%h z=%b c=%b dz=%b expected r=0000 z=1 c=1 dz=0",
                                 bus.result, bus.flag_zero, bus.flag_carry, bus.flag_dz);
        end
        model_prev = 16'h0000;
    endtask

    task automatic test_div;
        alu_op_t     ops [4] = '{DIV, MOD, DIV, MOD};
        bit          sg  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] av  [4] = '{16'd100, 16'd100, 16'hFF9C, 16'hFF9C};
        logic [15:0] ex  [4] = '{16'd14, 16'd2, 16'hFFF2, 16'hFFFE};
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], sg[i], av[i], 16'd7);
            checks++;
            if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL div%0d_busy_in_ready: got %b expected 0", i, bus.in_ready); end
            wait_result(lat);
            checks++;
            if (lat !== 17) begin failures++; $display("FAIL div%0d_latency: got %0d expected 17", i, lat); end
            checks++;
            if (bus.result !== ex[i] || bus.flag_dz !== 1'b0) begin
                failures++; $display("FAIL div%0d_result: got %h dz=%b expected %h dz=0", i, bus.result, bus.flag_dz, ex[i]);
            end
            model_prev = ex[i];
        end
    endtask

    task automatic test_div_zero;
        alu_op_t     ops [3] = '{DIV, MOD, DIV};
        bit          sg  [3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] av  [3] = '{16'h1234, 16'h1234, 16'h8000};
        logic [15:0] bv  [3] = '{16'h0000, 16'h0000, 16'hFFFF};
        logic [15:0] ex  [3] = '{16'hFFFF, 16'h1234, 16'h8000};
        bit          edz [3] = '{1'b1, 1'b1, 1'b0};
        int          elat[3] = '{1, 1, 17};
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], sg[i], av[i], bv[i]);
            wait_result(lat);
            checks++;
            if (lat !== elat[i]) begin failures++; $display("FAIL dz%0d_latency: got %0d expected %0d", i, lat, elat[i]); end
            checks++;
            if (bus.result !== ex[i] || bus.flag_dz !== edz[i]) begin
                failures++; $display("FAIL dz%0d_result: got %h dz=%b expected %h dz=%b", i, bus.result, bus.flag_dz, ex[i], edz[i]);
            end
            model_prev = ex[i];
        end
    endtask

    task automatic test_backpressure;
        int lat;
        @(posedge clk); #1;           // let the previous result drain
        bus.out_ready = 1'b0;
        issue(CMP, 1'b1, 16'hFFFF, 16'h0001);
        wait_result(lat);
        drive(ADD, 1'b0, 16'd2, 16'd3);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.result, bus.flag_carry} !== {1'b1, 1'b0, 16'h0001, 1'b0}) begin
                failures++; $display("FAIL bp_hold%0d: got ov=%b ir=%b r=%h c=%b expected ov=1 ir=0 r=0001 c=0",
                                     i, bus.out_valid, bus.in_ready, bus.result, bus.flag_carry);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== 16'd5) begin
            failures++; $display("FAIL bp_next_accept: got ov=%b r=%h expected ov=1 r=0005", bus.out_valid, bus.result);
        end
        model_prev = 16'd5;
    endtask

    task automatic test_reset_mid_div;
        int lat;
        bit seen = 1'b0;
        issue(DIV, 1'b0, 16'd1000, 16'd3);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.result !== 16'h0) begin
            failures++; $display("FAIL rst_div_idle: got ir=%b r=%h expected ir=1 r=0000", bus.in_ready, bus.result);
        end
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL rst_div_no_result: got out_valid seen=%b expected 0", seen); end
        issue(ADD, 1'b0, 16'd2, 16'd2);
        wait_result(lat);
        checks++;
        if (lat !== 1 || bus.result !== 16'd4) begin
            failures++; $display("FAIL rst_div_add_after: got lat=%0d r=%h expected lat=1 r=0004", lat, bus.result);
        end
        model_prev = 16'd4;
    endtask

    task automatic test_back_to_back;
        logic [18:0] pend;
        logic [15:0] a, b, r;
        bit          s, z, c, dz;
        alu_op_t     o;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                checks++;
                if ({bus.out_valid, bus.result, bus.flag_zero, bus.flag_carry, bus.flag_dz} !== {1'b1, pend}) begin
                    failures++; $display("FAIL b2b%0d: got ov=%b r=%h z=%b c=%b dz=%b expected ov=1 r=%h z=%b c=%b dz=%b", i,
                                         bus.out_valid, bus.result, bus.flag_zero, bus.flag_carry, bus.flag_dz,
                                         pend[18:3], pend[2], pend[1], pend[0]);
                end
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b%0d_in_ready: got %b expected 1", i, bus.in_ready); end
            o = alu_op_t'(4'($urandom_range(0, 15)));
            if (is_divmod(o)) o = SUB;
            s = 1'($urandom_range(0, 1));
            a = 16'($urandom());
            b = (o == SHL || o == SHR) ? 16'($urandom_range(0, 20)) : 16'($urandom());
            model(o, s, a, b, model_prev, r, z, c, dz);
            model_prev = r;
            pend = {r, z, c, dz};
            drive(o, s, a, b);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.result, bus.flag_zero, bus.flag_carry, bus.flag_dz} !== {1'b1, pend}) begin
            failures++; $display("FAIL b2b_last: got ov=%b r=%h expected ov=1 r=%h", bus.out_valid, bus.result, pend[18:3]);
        end
    endtask

    task automatic test_random;
        logic [15:0] a, b, r;
        bit          s, z, c, dz;
        alu_op_t     o;
        int          lat, elat;
        for (int i = 0; i < 60; i++) begin
            o = alu_op_t'(4'($urandom_range(0, 15)));
            s = 1'($urandom_range(0, 1));
            a = 16'($urandom());
            case ($urandom_range(0, 7))
                0: b = 16'h0;
                1, 2: b = 16'($urandom_range(0, 20));
                3: begin a = 16'h8000; b = 16'hFFFF; end
                default: b = 16'($urandom());
            endcase
            model(o, s, a, b, model_prev, r, z, c, dz);
            elat = (is_divmod(o) && b != 0) ? 17 : 1;
            issue(o, s, a, b);
            wait_result(lat);
            checks++;
            if (lat !== elat) begin failures++; $display("FAIL rand%0d_latency op=%0d: got %0d expected %0d", i, o, lat, elat); end
            checks++;
            if ({bus.result, bus.flag_zero, bus.flag_carry, bus.flag_dz} !== {r, z, c, dz}) begin
                failures++; $display("FAIL rand%0d op=%0d s=%b a=%h b=%h: got r=%h z=%b c=%b dz=%b expected r=%h z=%b c=%b dz=%b",
                                     i, o, s, a, b, bus.result, bus.flag_zero, bus.flag_carry, bus.flag_dz, r, z, c, dz);
            end
            model_prev = r;
        end
    endtask

    task automatic test_w8;
        alu_op_t    ops [4] = '{CLZ, CTZ, POPCNT, SHR};
        bit         sg  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] av  [4] = '{8'h00, 8'h80, 8'hFF, 8'h80};
        logic [7:0] bv  [4] = '{8'h00, 8'h00, 8'h00, 8'h09};
        logic [7:0] ex  [4] = '{8'd8, 8'd7, 8'd8, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            bus8.op = ops[i]; bus8.op_signed = sg[i]; bus8.ra = av[i]; bus8.rb = bv[i];
            bus8.in_valid = 1'b1;
            checks++;
            if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL w8_%0d_in_ready: got %b expected 1", i, bus8.in_ready); end
            @(posedge clk); #1;
            bus8.in_valid = 1'b0;
            checks++;
            if (bus8.out_valid !== 1'b1 || bus8.result !== ex[i]) begin
                failures++; $display("FAIL w8_%0d_result: got ov=%b r=%h expected ov=1 r=%h", i, bus8.out_valid, bus8.result, ex[i]);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.in_valid   = 1'b0; bus.op = ADD; bus.op_signed = 1'b0;
        bus.ra         = '0;   bus.rb = '0;  bus.out_ready = 1'b1;
        bus8.in_valid  = 1'b0; bus8.op = ADD; bus8.op_signed = 1'b0;
        bus8.ra        = '0;   bus8.rb = '0;  bus8.out_ready = 1'b1;
        model_prev     = 16'h0;
        test_reset();
        test_add();
        test_div();
        test_div_zero();
        test_backpressure();
        test_reset_mid_div();
        test_back_to_back();
        test_random();
        test_w8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
